// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: decides per-cycle load enables and merge selects for the
// four inter-stage buffers and the PC. It also tracks memory responses that
// arrive during a multi-cycle freeze, and keeps saturating stall/flush counters.

package buffer_load_mux;
    typedef enum logic [2:0] {
        use_old,
        load_invalid,
        load_ifid,
        load_idex,
        load_exmem,
        load_memwb
    } buffer_sel_t;
endpackage

module pipeline_ctrl
    import buffer_load_mux::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    input  logic             exmem_mem_req,
    input  logic             idex_valid,
    input  logic             idex_is_load,
    input  logic [4:0]       idex_rd,
    input  logic             ifid_valid,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic             ex_mispredict,
    output logic             imem_read,
    output logic             dmem_req,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output buffer_sel_t      ifid_sel,
    output buffer_sel_t      idex_sel,
    output buffer_sel_t      exmem_sel,
    output buffer_sel_t      memwb_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic imem_done;
    logic dmem_done;
    logic i_ok;
    logic d_ok;
    logic advance;
    logic load_use;
    logic do_flush;
    logic do_bubble;

    // Request gating and the global advance decision
    always_comb begin
        imem_read = !rst && !imem_done;
        dmem_req  = !rst && exmem_mem_req && !dmem_done;
        i_ok      = imem_done || imem_resp;
        d_ok      = !exmem_mem_req || dmem_done || dmem_resp;
        advance   = i_ok && d_ok;
        load_use  = idex_valid && idex_is_load && (idex_rd != 5'd0) && ifid_valid &&
                    ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));
        do_flush  = !rst && advance && ex_mispredict;
        do_bubble = !rst && advance && !ex_mispredict && load_use;
    end

    // Per-buffer load/select decision; reset and freeze share the hold default
    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_sel   = use_old;
        idex_sel   = use_old;
        exmem_sel  = use_old;
        memwb_sel  = use_old;
        if (!rst && advance) begin
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            exmem_sel  = load_exmem;
            memwb_sel  = load_memwb;
            idex_load  = 1'b1;
            if (ex_mispredict) begin
                pc_load   = 1'b1;
                ifid_load = 1'b1;
                ifid_sel  = load_invalid;
                idex_sel  = load_invalid;
            end else if (load_use) begin
                idex_sel  = load_invalid;
            end else begin
                pc_load   = 1'b1;
                ifid_load = 1'b1;
                ifid_sel  = load_ifid;
                idex_sel  = load_idex;
            end
        end
    end

    // Remember which memory side already answered while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else if (advance) begin
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else begin
            if (imem_resp) imem_done <= 1'b1;
            if (dmem_resp) dmem_done <= 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((!advance || do_bubble) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (do_flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner cases
// and randomized stimulus compared against a behavioural model.

module tb_pipeline_ctrl;
    import buffer_load_mux::*;

    logic clk = 1'b0;
    logic rst;
    logic imem_resp, dmem_resp, exmem_mem_req;
    logic idex_valid, idex_is_load;
    logic [4:0] idex_rd;
    logic ifid_valid;
    logic [4:0] ifid_rs1, ifid_rs2;
    logic ifid_uses_rs1, ifid_uses_rs2, ex_mispredict;

    logic imem_read, dmem_req, pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    buffer_sel_t ifid_sel, idex_sel, exmem_sel, memwb_sel;
    logic [31:0] stall_count, flush_count;

    logic imem_read4, dmem_req4, pc_load4, ifid_load4, idex_load4, exmem_load4, memwb_load4;
    buffer_sel_t ifid_sel4, idex_sel4, exmem_sel4, memwb_sel4;
    logic [3:0] stall_count4, flush_count4;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .exmem_mem_req(exmem_mem_req), .idex_valid(idex_valid), .idex_is_load(idex_is_load),
        .idex_rd(idex_rd), .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2), .ex_mispredict(ex_mispredict),
        .imem_read(imem_read), .dmem_req(dmem_req), .pc_load(pc_load),
        .ifid_load(ifid_load), .idex_load(idex_load), .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_sel(ifid_sel), .idex_sel(idex_sel), .exmem_sel(exmem_sel), .memwb_sel(memwb_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .exmem_mem_req(exmem_mem_req), .idex_valid(idex_valid), .idex_is_load(idex_is_load),
        .idex_rd(idex_rd), .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2), .ex_mispredict(ex_mispredict),
        .imem_read(imem_read4), .dmem_req(dmem_req4), .pc_load(pc_load4),
        .ifid_load(ifid_load4), .idex_load(idex_load4), .exmem_load(exmem_load4), .memwb_load(memwb_load4),
        .ifid_sel(ifid_sel4), .idex_sel(idex_sel4), .exmem_sel(exmem_sel4), .memwb_sel(memwb_sel4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_RESET, M_FREEZE, M_FLUSH, M_BUBBLE, M_NORMAL} mode_t;

    bit m_idone, m_ddone;
    longint m_stall, m_flush, m_stall4, m_flush4;

    function automatic mode_t model_mode();
        bit i_ok, d_ok, hazard;
        if (rst) return M_RESET;
        i_ok = m_idone || imem_resp;
        d_ok = !exmem_mem_req || m_ddone || dmem_resp;
        if (!(i_ok && d_ok)) return M_FREEZE;
        if (ex_mispredict) return M_FLUSH;
        hazard = idex_valid && idex_is_load && idex_rd != 0 && ifid_valid &&
                 ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd));
        if (hazard) return M_BUBBLE;
        return M_NORMAL;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input mode_t md);
        logic [4:0] e_loads;
        buffer_sel_t e0, e1, e2, e3;
        case (md)
            M_FLUSH:  begin e_loads = 5'b11111; e0 = load_invalid; e1 = load_invalid; e2 = load_exmem; e3 = load_memwb; end
            M_BUBBLE: begin e_loads = 5'b00111; e0 = use_old;      e1 = load_invalid; e2 = load_exmem; e3 = load_memwb; end
            M_NORMAL: begin e_loads = 5'b11111; e0 = load_ifid;    e1 = load_idex;    e2 = load_exmem; e3 = load_memwb; end
            default:  begin e_loads = 5'b00000; e0 = use_old;      e1 = use_old;      e2 = use_old;    e3 = use_old;    end
        endcase
        chk("loads", {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, e_loads);
        chk("loads4", {pc_load4, ifid_load4, idex_load4, exmem_load4, memwb_load4}, e_loads);
        chk("ifid_sel", ifid_sel, e0);
        chk("idex_sel", idex_sel, e1);
        chk("exmem_sel", exmem_sel, e2);
        chk("memwb_sel", memwb_sel, e3);
        chk("imem_read", imem_read, !rst && !m_idone);
        chk("dmem_req", dmem_req, !rst && exmem_mem_req && !m_ddone);
    endtask

    task automatic update_model(input mode_t md);
        if (md == M_RESET) begin
            m_idone = 0; m_ddone = 0;
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        end else begin
            if (md == M_FREEZE) begin
                if (imem_resp) m_idone = 1;
                if (dmem_resp) m_ddone = 1;
            end else begin
                m_idone = 0; m_ddone = 0;
            end
            if (md == M_FREEZE || md == M_BUBBLE) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (md == M_FLUSH) begin
                if (m_flush < 64'hFFFF_FFFF) m_flush++;
                if (m_flush4 < 15) m_flush4++;
            end
        end
    endtask

    // One clock: check combinational outputs before the edge, counters after it
    task automatic cycle();
        mode_t md;
        #2;
        md = model_mode();
        check_outputs(md);
        @(posedge clk);
        update_model(md);
        #1;
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("stall_count4", stall_count4, m_stall4);
        chk("flush_count4", flush_count4, m_flush4);
    endtask

    task automatic clear_inputs();
        imem_resp = 0; dmem_resp = 0; exmem_mem_req = 0;
        idex_valid = 0; idex_is_load = 0; idex_rd = 0;
        ifid_valid = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; ex_mispredict = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic set_hazard(input logic [4:0] rd);
        idex_valid = 1; idex_is_load = 1; idex_rd = rd;
        ifid_valid = 1; ifid_rs2 = rd; ifid_uses_rs2 = 1;
        ifid_rs1 = 5'd7; ifid_uses_rs1 = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic imem_resp, dmem_resp, mem_req, idex_valid, idex_is_load;
        logic [4:0] idex_rd;
        logic ifid_valid;
        logic [4:0] rs1, rs2;
        logic u1, u2, misp;
        logic [4:0] exp_loads;
        buffer_sel_t exp_ifid_sel, exp_idex_sel;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Each vector leaves the done flags clear so the table is order-independent.
        vecs[0]  = '{1,0,0, 0,0,5'd0, 0,5'd0,5'd0, 0,0,0, 5'b11111, load_ifid, load_idex};
        vecs[1]  = '{0,0,0, 0,0,5'd0, 0,5'd0,5'd0, 0,0,0, 5'b00000, use_old, use_old};
        vecs[2]  = '{1,1,1, 0,0,5'd0, 0,5'd0,5'd0, 0,0,0, 5'b11111, load_ifid, load_idex};
        vecs[3]  = '{1,0,0, 1,1,5'd3, 1,5'd3,5'd9, 1,0,0, 5'b00111, use_old, load_invalid};
        vecs[4]  = '{1,0,0, 1,1,5'd3, 1,5'd3,5'd9, 0,0,0, 5'b11111, load_ifid, load_idex};
        vecs[5]  = '{1,0,0, 1,1,5'd0, 1,5'd0,5'd0, 1,1,0, 5'b11111, load_ifid, load_idex};
        vecs[6]  = '{1,0,0, 1,1,5'd4, 0,5'd4,5'd4, 1,1,0, 5'b11111, load_ifid, load_idex};
        vecs[7]  = '{1,0,0, 1,0,5'd4, 1,5'd4,5'd4, 1,1,0, 5'b11111, load_ifid, load_idex};
        vecs[8]  = '{1,0,0, 1,1,5'd6, 1,5'd1,5'd6, 0,1,1, 5'b11111, load_invalid, load_invalid};
        vecs[9]  = '{0,0,0, 0,0,5'd0, 0,5'd0,5'd0, 0,0,1, 5'b00000, use_old, use_old};
        vecs[10] = '{0,0,1, 0,0,5'd0, 0,5'd0,5'd0, 0,0,0, 5'b00000, use_old, use_old};
    end

    // ---------------- test sequence ----------------
    initial begin
        clear_inputs();
        rst = 1;
        m_idone = 0; m_ddone = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;

        // Reset sequence followed by steady fetch, no data accesses
        do_reset();
        imem_resp = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("post_reset_pc_load", pc_load, 1'b1);
        end
        chk("post_reset_stall", stall_count, 0);

        // Vector table
        do_reset();
        foreach (vecs[k]) begin
            imem_resp = vecs[k].imem_resp; dmem_resp = vecs[k].dmem_resp;
            exmem_mem_req = vecs[k].mem_req; idex_valid = vecs[k].idex_valid;
            idex_is_load = vecs[k].idex_is_load; idex_rd = vecs[k].idex_rd;
            ifid_valid = vecs[k].ifid_valid; ifid_rs1 = vecs[k].rs1; ifid_rs2 = vecs[k].rs2;
            ifid_uses_rs1 = vecs[k].u1; ifid_uses_rs2 = vecs[k].u2; ex_mispredict = vecs[k].misp;
            #1;
            chk($sformatf("vec%0d_loads", k), {pc_load, ifid_load, idex_load, exmem_load, memwb_load}, vecs[k].exp_loads);
            chk($sformatf("vec%0d_ifid_sel", k), ifid_sel, vecs[k].exp_ifid_sel);
            chk($sformatf("vec%0d_idex_sel", k), idex_sel, vecs[k].exp_idex_sel);
            cycle();
        end

        // Split responses: imem answers in cycle 1, dmem in cycle 4
        do_reset();
        exmem_mem_req = 1; imem_resp = 1;
        cycle();
        imem_resp = 0;
        #1 chk("split_imem_read_dropped", imem_read, 1'b0);
        cycle();
        cycle();
        dmem_resp = 1;
        #1 chk("split_advance_pc_load", pc_load, 1'b1);
        cycle();
        chk("split_stall3", stall_count, 3);
        dmem_resp = 0; exmem_mem_req = 0;
        #1 chk("split_imem_read_again", imem_read, 1'b1);
        cycle();

        // Load-use hazard, then cleared; then rd == 0 gives no stall
        do_reset();
        imem_resp = 1;
        set_hazard(5'd5);
        #1 chk("lu_pc_load", pc_load, 1'b0);
        chk("lu_ifid_load", ifid_load, 1'b0);
        chk("lu_idex_sel", idex_sel, load_invalid);
        cycle();
        idex_valid = 0; idex_is_load = 0;
        #1 chk("lu_after_pc_load", pc_load, 1'b1);
        cycle();
        set_hazard(5'd0);
        #1 chk("lu_rd0_pc_load", pc_load, 1'b1);
        cycle();
        chk("lu_stall1", stall_count, 1);

        // Mispredict while dmem pending for two cycles
        do_reset();
        exmem_mem_req = 1; imem_resp = 1; ex_mispredict = 1;
        cycle();
        cycle();
        dmem_resp = 1;
        #1 chk("mf_ifid_sel", ifid_sel, load_invalid);
        chk("mf_pc_load", pc_load, 1'b1);
        cycle();
        chk("mf_flush1", flush_count, 1);
        chk("mf_stall2", stall_count, 2);

        // Mispredict and load-use together: flush wins
        do_reset();
        imem_resp = 1; ex_mispredict = 1;
        set_hazard(5'd9);
        cycle();
        chk("ml_flush1", flush_count, 1);
        chk("ml_stall0", stall_count, 0);

        // Saturation of the 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_stall15", stall_count4, 15);
        cycle();
        chk("sat_stall15_held", stall_count4, 15);

        // Randomized run against the model (occasional reset, including mid-freeze)
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            imem_resp = ($urandom_range(0, 9) < 6);
            dmem_resp = ($urandom_range(0, 1) == 1);
            exmem_mem_req = ($urandom_range(0, 1) == 1);
            idex_valid = ($urandom_range(0, 3) != 0);
            idex_is_load = ($urandom_range(0, 1) == 1);
            idex_rd = 5'($urandom_range(0, 3));
            ifid_valid = ($urandom_range(0, 3) != 0);
            ifid_rs1 = 5'($urandom_range(0, 3));
            ifid_rs2 = 5'($urandom_range(0, 3));
            ifid_uses_rs1 = ($urandom_range(0, 1) == 1);
            ifid_uses_rs2 = ($urandom_range(0, 1) == 1);
            ex_mispredict = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
